// File: rtl/key_generator_inv_if.sv
// Round-key streaming bundle between the decryption datapath and the inverse AES-128 key scheduler.
// KEY_SCHED_SELFCHECK_EN adds the key_err status line.
interface key_generator_inv_if #(parameter int BLOCK_LENGTH = 128);
  logic                    start;
  logic [BLOCK_LENGTH-1:0] key;
  logic                    busy;
  logic                    rk_valid;
  logic                    rk_ready;
  logic [BLOCK_LENGTH-1:0] rk;
  logic [3:0]              rk_index;
  logic                    done;
`ifdef KEY_SCHED_SELFCHECK_EN
  logic                    key_err;

  modport master (output start, key, rk_ready,
                  input  busy, rk_valid, rk, rk_index, done, key_err);
  modport slave  (input  start, key, rk_ready,
                  output busy, rk_valid, rk, rk_index, done, key_err);
`else
  modport master (output start, key, rk_ready,
                  input  busy, rk_valid, rk, rk_index, done);
  modport slave  (input  start, key, rk_ready,
                  output busy, rk_valid, rk, rk_index, done);
`endif
endinterface

// File: rtl/key_generator_inv.sv
// On-the-fly AES-128 inverse key schedule: expands forward to k10, then streams k10..k0.
// Optional macro KEY_SCHED_SELFCHECK_EN: key_err flags a k0 that differs from the latched key.

// AES S-box: multiplicative inverse in GF(2^8) (a^254) followed by the affine map.
module key_generator_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] xx;
    p  = 8'h00;
    xx = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ xx;
      xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  always_comb begin
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

// g(): RotWord, SubWord per byte lane, Rcon into the top byte.
module key_generator_inv_g (
  input  logic [31:0] w,
  input  logic [7:0]  rcon,
  output logic [31:0] g
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][7:0] rot;
  logic [NUM_LANES-1:0][7:0] sub;

  assign rot = {w[23:0], w[31:24]};

  generate
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      key_generator_inv_sbox u_sbox (.a(rot[l]), .s(sub[l]));
    end
  endgenerate

  assign g = sub ^ {rcon, 24'h000000};
endmodule

module key_generator_inv #(
  parameter int BLOCK_LENGTH = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  key_generator_inv_if.slave   bus
);
  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_STREAM} state_t;

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t                  state_q, state_d;
  logic [BLOCK_LENGTH-1:0] cur_q, cur_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [3:0]              idx_q, idx_d;
  logic                    done_q, done_d;
`ifdef KEY_SCHED_SELFCHECK_EN
  logic [BLOCK_LENGTH-1:0] key_reg_q, key_reg_d;
  logic                    key_err_q, key_err_d;
`endif

  logic [31:0]             w0, w1, w2, w3;
  logic [31:0]             g_in, g_out;
  logic [7:0]              g_rc;
  logic [BLOCK_LENGTH-1:0] fwd_key, inv_key;
  logic                    xfer;

  assign {w0, w1, w2, w3} = cur_q;

  // One g() serves both directions: EXPAND feeds w3, STREAM feeds the recovered w3 = w6^w7.
  assign g_in = (state_q == S_EXPAND) ? w3 : (w2 ^ w3);
  assign g_rc = rcon((state_q == S_EXPAND) ? cnt_q : idx_q);

  key_generator_inv_g u_g (.w(g_in), .rcon(g_rc), .g(g_out));

  always_comb begin
    logic [31:0] n0, n1, n2;
    n0      = w0 ^ g_out;
    n1      = w1 ^ n0;
    n2      = w2 ^ n1;
    fwd_key = {n0, n1, n2, w3 ^ n2};
    // Here cur holds {w4,w5,w6,w7}; g_out was computed from w6^w7.
    inv_key = {w0 ^ g_out, w0 ^ w1, w1 ^ w2, w2 ^ w3};
  end

  assign xfer = (state_q == S_STREAM) && bus.rk_ready;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
`ifdef KEY_SCHED_SELFCHECK_EN
    key_reg_d = key_reg_q;
    key_err_d = key_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cur_d   = bus.key;
          cnt_d   = 4'd1;
          state_d = S_EXPAND;
`ifdef KEY_SCHED_SELFCHECK_EN
          key_reg_d = bus.key;
          key_err_d = 1'b0;
`endif
        end
      end
      S_EXPAND: begin
        cur_d = fwd_key;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd10) begin
          state_d = S_STREAM;
          idx_d   = 4'd10;
        end
      end
      S_STREAM: begin
        if (xfer) begin
          if (idx_q != 4'd0) begin
            cur_d = inv_key;
            idx_d = idx_q - 4'd1;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
`ifdef KEY_SCHED_SELFCHECK_EN
            key_err_d = (cur_q != key_reg_q);
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      cnt_q   <= 4'd0;
      idx_q   <= 4'd0;
      done_q  <= 1'b0;
`ifdef KEY_SCHED_SELFCHECK_EN
      key_reg_q <= '0;
      key_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
`ifdef KEY_SCHED_SELFCHECK_EN
      key_reg_q <= key_reg_d;
      key_err_q <= key_err_d;
`endif
    end
  end

  // rk/rk_index are zeroed outside STREAM so stale keys never appear on the bus.
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.rk_valid = (state_q == S_STREAM);
  assign bus.rk       = (state_q == S_STREAM) ? cur_q : '0;
  assign bus.rk_index = (state_q == S_STREAM) ? idx_q : 4'd0;
  assign bus.done     = done_q;
`ifdef KEY_SCHED_SELFCHECK_EN
  assign bus.key_err  = key_err_q;
`endif
endmodule
